// File: rtl/ldst_cluster_scheduler.sv
// ldst_cluster_scheduler
//
// Sequences one vector load/store instruction across all clusters of the
// multi-cluster vector unit. The global vl is split element-interleaved
// (cluster c owns elements c, c+N, c+2N, ...). A per-cluster request goes
// out over an independent valid/ready handshake, the per-cluster done
// pulses are collected, and one response is returned upstream.
//
// Optional feature: define LDST_SCHED_TIMEOUT_EN to enable a BUSY watchdog.
// When it fires, the instruction ends with resp_err_o=1. Without the macro
// resp_err_o is tied low and BUSY waits indefinitely.
//
// Ports:
//   clk_i, rst_i            clock, async active-high reset
//   req_valid_i/req_ready_o instruction handshake
//   req_vl_i, req_vsew_i    global vl and element width
//   req_store_i, req_id_i   direction (1 = store) and tag
//   cl_valid_o/cl_ready_i   per-cluster request handshakes
//   cl_vl_o                 per-cluster element count; cluster c at [c*VlW +: VlW]
//   cl_vsew_o, cl_store_o,
//   cl_id_o                 broadcast copies of the latched request
//   cl_done_i               per-cluster single-cycle completion pulses
//   resp_valid_o/resp_ready_i response handshake
//   resp_id_o, resp_err_o   response tag and watchdog error flag
//   spurious_o              sticky: done pulse seen for a cluster not issued
//
// state | meaning
// IDLE  | ready for a new instruction
// BUSY  | requests outstanding or completions pending
// RESP  | response held until resp_ready_i
module ldst_cluster_scheduler #(
  parameter int unsigned NrClusters    = 4,
  parameter type         vlen_cl_t     = logic [15:0],
  parameter int unsigned IdWidth       = 4,
  parameter int unsigned TimeoutCycles = 1024,
  localparam int unsigned VlW          = $bits(vlen_cl_t)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [VlW-1:0]             req_vl_i,
  input  logic [2:0]                 req_vsew_i,
  input  logic                       req_store_i,
  input  logic [IdWidth-1:0]         req_id_i,
  output logic [NrClusters-1:0]      cl_valid_o,
  input  logic [NrClusters-1:0]      cl_ready_i,
  output logic [NrClusters*VlW-1:0]  cl_vl_o,
  output logic [2:0]                 cl_vsew_o,
  output logic                       cl_store_o,
  output logic [IdWidth-1:0]         cl_id_o,
  input  logic [NrClusters-1:0]      cl_done_i,
  output logic                       resp_valid_o,
  input  logic                       resp_ready_i,
  output logic [IdWidth-1:0]         resp_id_o,
  output logic                       resp_err_o,
  output logic                       spurious_o
);

  localparam int unsigned L = $clog2(NrClusters);

  if ((NrClusters < 2) || ((1 << L) != NrClusters)) begin : g_bad_nr_clusters
    $error("NrClusters must be a power of two >= 2");
  end
  if (TimeoutCycles < 2) begin : g_bad_timeout
    $error("TimeoutCycles must be >= 2");
  end

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e                 state_q, state_d;
  logic [NrClusters-1:0]  issued_q, issued_d;
  logic [NrClusters-1:0]  done_q, done_d;
  logic                   spurious_q, spurious_d;
  logic [VlW-1:0]         share_d [NrClusters];
  logic [VlW-1:0]         cl_vl_q [NrClusters];
  logic [NrClusters-1:0]  zero_share;
  logic [2:0]             vsew_q;
  logic                   store_q;
  logic [IdWidth-1:0]     id_q;
  logic                   accept;
  logic [NrClusters-1:0]  cl_hs;
  logic [NrClusters-1:0]  done_ok;
  logic [NrClusters-1:0]  done_stray;

  // Shares depend only on the incoming vl; the remainder elements go to the
  // lowest-numbered clusters.
  always_comb begin
    for (int c = 0; c < NrClusters; c++) begin
      share_d[c] = req_vl_i >> L;
      if (L'(c) < req_vl_i[L-1:0]) share_d[c] = share_d[c] + VlW'(1);
      zero_share[c] = (share_d[c] == '0);
    end
  end

  assign accept       = (state_q == IDLE) && req_valid_i;
  assign req_ready_o  = (state_q == IDLE);
  assign resp_valid_o = (state_q == RESP);
  assign cl_valid_o   = (state_q == BUSY) ? ~issued_q : '0;
  assign cl_hs        = cl_valid_o & cl_ready_i;
  // A done pulse is legal for an issued cluster or one handshaking this cycle;
  // outside BUSY every pulse is stray.
  assign done_ok      = (state_q == BUSY) ? (cl_done_i & (issued_q | cl_hs)) : '0;
  assign done_stray   = cl_done_i & ~done_ok;

`ifdef LDST_SCHED_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles) + 1;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  assign resp_err_o = err_q;
`else
  assign resp_err_o = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    issued_d   = issued_q;
    done_d     = done_q;
    spurious_d = spurious_q | (|done_stray);
`ifdef LDST_SCHED_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          issued_d = zero_share;
          done_d   = zero_share;
          state_d  = (req_vl_i == '0) ? RESP : BUSY;
`ifdef LDST_SCHED_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      BUSY: begin
        issued_d = issued_q | cl_hs;
        done_d   = done_q | done_ok;
        if (&done_d) begin
          state_d = RESP;
        end
`ifdef LDST_SCHED_TIMEOUT_EN
        else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
          // Watchdog fires on the cycle the counter would reach the limit.
          state_d = RESP;
          err_d   = 1'b1;
        end
        cnt_d = cnt_q + CntW'(1);
`endif
      end
      RESP: begin
        if (resp_ready_i) begin
          state_d = IDLE;
`ifdef LDST_SCHED_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      issued_q   <= '0;
      done_q     <= '0;
      spurious_q <= 1'b0;
`ifdef LDST_SCHED_TIMEOUT_EN
      cnt_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      done_q     <= done_d;
      spurious_q <= spurious_d;
`ifdef LDST_SCHED_TIMEOUT_EN
      cnt_q      <= cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vsew_q  <= '0;
      store_q <= 1'b0;
      id_q    <= '0;
      for (int c = 0; c < NrClusters; c++) cl_vl_q[c] <= '0;
    end else if (accept) begin
      vsew_q  <= req_vsew_i;
      store_q <= req_store_i;
      id_q    <= req_id_i;
      for (int c = 0; c < NrClusters; c++) cl_vl_q[c] <= share_d[c];
    end
  end

  always_comb begin
    for (int c = 0; c < NrClusters; c++) cl_vl_o[c*VlW +: VlW] = cl_vl_q[c];
  end

  assign cl_vsew_o  = vsew_q;
  assign cl_store_o = store_q;
  assign cl_id_o    = id_q;
  assign resp_id_o  = id_q;
  assign spurious_o = spurious_q;

endmodule

// File: tb/tb_ldst_cluster_scheduler.sv
module tb_ldst_cluster_scheduler;

  localparam int NC  = 4;
  localparam int VLW = 16;
  localparam int IDW = 4;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              req_valid_i = 1'b0;
  logic              req_ready_o;
  logic [VLW-1:0]    req_vl_i = '0;
  logic [2:0]        req_vsew_i = '0;
  logic              req_store_i = 1'b0;
  logic [IDW-1:0]    req_id_i = '0;
  logic [NC-1:0]     cl_valid_o;
  logic [NC-1:0]     cl_ready_i = '0;
  logic [NC*VLW-1:0] cl_vl_o;
  logic [2:0]        cl_vsew_o;
  logic              cl_store_o;
  logic [IDW-1:0]    cl_id_o;
  logic [NC-1:0]     cl_done_i = '0;
  logic              resp_valid_o;
  logic              resp_ready_i = 1'b0;
  logic [IDW-1:0]    resp_id_o;
  logic              resp_err_o;
  logic              spurious_o;

  ldst_cluster_scheduler #(
    .NrClusters   (NC),
    .vlen_cl_t    (logic [VLW-1:0]),
    .IdWidth      (IDW),
    .TimeoutCycles(16)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_vl_i     (req_vl_i),
    .req_vsew_i   (req_vsew_i),
    .req_store_i  (req_store_i),
    .req_id_i     (req_id_i),
    .cl_valid_o   (cl_valid_o),
    .cl_ready_i   (cl_ready_i),
    .cl_vl_o      (cl_vl_o),
    .cl_vsew_o    (cl_vsew_o),
    .cl_store_o   (cl_store_o),
    .cl_id_o      (cl_id_o),
    .cl_done_i    (cl_done_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_id_o    (resp_id_o),
    .resp_err_o   (resp_err_o),
    .spurious_o   (spurious_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [VLW-1:0]    vl;
    logic [IDW-1:0]    id;
    logic [2:0]        vsew;
    logic              st;
    logic [NC*VLW-1:0] exp_vl;   // {c3, c2, c1, c0}
    logic [NC-1:0]     exp_mask;
    int                exp_lat;  // cycles from accept to resp_valid_o
  } vec_t;

  vec_t vecs [7];

  // Drive a request at the current negedge; returns after the accept edge.
  task automatic send(input logic [VLW-1:0] vl, input logic [IDW-1:0] id,
                      input logic [2:0] vsew, input logic st);
    req_valid_i = 1'b1;
    req_vl_i    = vl;
    req_id_i    = id;
    req_vsew_i  = vsew;
    req_store_i = st;
    @(negedge clk_i);
    req_valid_i = 1'b0;
  endtask

  // All clusters ready, done in the same cycle as their valid.
  task automatic run_to_resp(input string name, output int lat);
    lat = 1;
    while (!resp_valid_o && lat < 40) begin
      cl_ready_i = '1;
      cl_done_i  = cl_valid_o;
      @(negedge clk_i);
      cl_done_i  = '0;
      lat++;
    end
    cl_ready_i = '0;
    if (!resp_valid_o) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_resp required=resp", name);
    end
  endtask

  task automatic resp_hs();
    resp_ready_i = 1'b1;
    @(negedge clk_i);
    resp_ready_i = 1'b0;
  endtask

  int lat;
  logic [NC*VLW-1:0] vl_snap;

  initial begin
    vecs[0] = '{vl: 16'd10,  id: 4'h3, vsew: 3'd2, st: 1'b1,
                exp_vl: {16'd2, 16'd2, 16'd3, 16'd3},     exp_mask: 4'b1111, exp_lat: 2};
    vecs[1] = '{vl: 16'd2,   id: 4'h6, vsew: 3'd0, st: 1'b0,
                exp_vl: {16'd0, 16'd0, 16'd1, 16'd1},     exp_mask: 4'b0011, exp_lat: 2};
    vecs[2] = '{vl: 16'd0,   id: 4'hA, vsew: 3'd1, st: 1'b1,
                exp_vl: {16'd0, 16'd0, 16'd0, 16'd0},     exp_mask: 4'b0000, exp_lat: 1};
    vecs[3] = '{vl: 16'd5,   id: 4'h1, vsew: 3'd3, st: 1'b0,
                exp_vl: {16'd1, 16'd1, 16'd1, 16'd2},     exp_mask: 4'b1111, exp_lat: 2};
    vecs[4] = '{vl: 16'd4,   id: 4'hF, vsew: 3'd2, st: 1'b1,
                exp_vl: {16'd1, 16'd1, 16'd1, 16'd1},     exp_mask: 4'b1111, exp_lat: 2};
    vecs[5] = '{vl: 16'd7,   id: 4'h8, vsew: 3'd1, st: 1'b0,
                exp_vl: {16'd1, 16'd2, 16'd2, 16'd2},     exp_mask: 4'b1111, exp_lat: 2};
    vecs[6] = '{vl: 16'd255, id: 4'h2, vsew: 3'd0, st: 1'b1,
                exp_vl: {16'd63, 16'd64, 16'd64, 16'd64}, exp_mask: 4'b1111, exp_lat: 2};

    // Reset values
    @(negedge clk_i);
    @(negedge clk_i);
    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_cl_valid", cl_valid_o, 0);
    chk("rst_resp_valid", resp_valid_o, 0);
    chk("rst_resp_err", resp_err_o, 0);
    chk("rst_spurious", spurious_o, 0);
    chk("rst_cl_vl", cl_vl_o, 0);
    chk("rst_bcast", {cl_vsew_o, cl_store_o, cl_id_o, resp_id_o}, 0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Table-driven single instructions
    foreach (vecs[i]) begin
      chk($sformatf("v%0d_req_ready", i), req_ready_o, 1);
      send(vecs[i].vl, vecs[i].id, vecs[i].vsew, vecs[i].st);
      chk($sformatf("v%0d_req_ready_busy", i), req_ready_o, 0);
      chk($sformatf("v%0d_cl_valid", i), cl_valid_o, vecs[i].exp_mask);
      chk($sformatf("v%0d_cl_vl", i), cl_vl_o, vecs[i].exp_vl);
      chk($sformatf("v%0d_bcast", i), {cl_vsew_o, cl_store_o, cl_id_o},
          {vecs[i].vsew, vecs[i].st, vecs[i].id});
      run_to_resp($sformatf("v%0d", i), lat);
      chk($sformatf("v%0d_resp_lat", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_resp_id", i), resp_id_o, vecs[i].id);
      chk($sformatf("v%0d_resp_err", i), resp_err_o, 0);
      chk($sformatf("v%0d_resp_cl_valid", i), cl_valid_o, 0);
      resp_hs();
      chk($sformatf("v%0d_back_idle", i), {req_ready_o, resp_valid_o}, 2'b10);
    end
    chk("tbl_spurious", spurious_o, 0);

    // Cluster 3 stalled for 5 cycles while the others complete
    send(16'd8, 4'h5, 3'd2, 1'b0);
    vl_snap = {16'd2, 16'd2, 16'd2, 16'd2};
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("stall%0d_valid3", k), cl_valid_o[3], 1);
      chk($sformatf("stall%0d_cl_vl", k), cl_vl_o, vl_snap);
      chk($sformatf("stall%0d_bcast", k), {cl_vsew_o, cl_id_o}, {3'd2, 4'h5});
      chk($sformatf("stall%0d_resp", k), resp_valid_o, 0);
      cl_ready_i = 4'b0111;
      cl_done_i  = cl_valid_o & 4'b0111;
      @(negedge clk_i);
      cl_done_i  = '0;
    end
    chk("stall_valid_only3", cl_valid_o, 4'b1000);
    cl_ready_i = 4'b1111;
    cl_done_i  = 4'b1000;
    @(negedge clk_i);
    cl_done_i  = '0;
    cl_ready_i = '0;
    chk("stall_resp_valid", resp_valid_o, 1);
    chk("stall_resp_id", resp_id_o, 4'h5);
    resp_hs();

    // Response back-pressure with a waiting request and a stray done in RESP
    send(16'd4, 4'h7, 3'd1, 1'b1);
    run_to_resp("bp_first", lat);
    req_valid_i = 1'b1;
    req_vl_i    = 16'd3;
    req_id_i    = 4'h9;
    req_vsew_i  = 3'd3;
    req_store_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp%0d_resp_valid", k), resp_valid_o, 1);
      chk($sformatf("bp%0d_req_ready", k), req_ready_o, 0);
      cl_done_i = (k == 1) ? 4'b0001 : 4'b0000;
      @(negedge clk_i);
      cl_done_i = '0;
    end
    chk("bp_spurious_set", spurious_o, 1);
    chk("bp_resp_id", resp_id_o, 4'h7);
    resp_ready_i = 1'b1;
    @(negedge clk_i);
    resp_ready_i = 1'b0;
    chk("bp_idle_bubble", {req_ready_o, resp_valid_o, cl_valid_o}, {1'b1, 1'b0, 4'b0000});
    @(negedge clk_i);
    req_valid_i = 1'b0;
    chk("bp_second_valid", cl_valid_o, 4'b0111);
    chk("bp_second_vl", cl_vl_o, {16'd0, 16'd1, 16'd1, 16'd1});
    chk("bp_second_id", cl_id_o, 4'h9);
    run_to_resp("bp_second", lat);
    chk("bp_second_resp_id", resp_id_o, 4'h9);
    resp_hs();
    chk("bp_spurious_sticky", spurious_o, 1);

`ifdef LDST_SCHED_TIMEOUT_EN
    // Cluster 1 never completes; watchdog ends the instruction
    send(16'd4, 4'h3, 3'd0, 1'b0);
    lat = 1;
    while (!resp_valid_o && lat < 60) begin
      cl_ready_i = '1;
      cl_done_i  = cl_valid_o & 4'b1101;
      @(negedge clk_i);
      cl_done_i  = '0;
      lat++;
    end
    cl_ready_i = '0;
    chk("to_resp_lat", lat, 17);
    chk("to_resp_err", resp_err_o, 1);
    chk("to_resp_id", resp_id_o, 4'h3);
    chk("to_cl_valid", cl_valid_o, 0);
    resp_hs();
    chk("to_err_cleared", resp_err_o, 0);
`endif

    // Reset in the middle of BUSY abandons the instruction
    send(16'd8, 4'h2, 3'd1, 1'b1);
    chk("rb_busy_valid", cl_valid_o, 4'b1111);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk("rb_cl_valid", cl_valid_o, 0);
    chk("rb_req_ready", req_ready_o, 1);
    chk("rb_resp", {resp_valid_o, resp_err_o}, 0);
    chk("rb_spurious", spurious_o, 0);
    chk("rb_cl_vl", cl_vl_o, 0);
    chk("rb_bcast", {cl_vsew_o, cl_store_o, cl_id_o, resp_id_o}, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    lat = 0;
    for (int k = 0; k < 6; k++) begin
      if (resp_valid_o || (cl_valid_o != 0)) lat++;
      @(negedge clk_i);
    end
    chk("rb_no_resp", lat, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
